rtlbusarb: RTL

Round-robin packet arbiter that shares one O-bit output bus among N requesters. Each requester presents valid/last/data; the arbiter locks onto one requester from its first accepted beat until its `last` beat is accepted. It then rotates priority. The arbiter drives a registered valid/ready output stage, and its one-hot owner vector doubles as the select for the team's one-hot bus selector.

---
 rtl/rtlbusarb.sv | 69 ++++++
 1 files changed

// File: rtl/rtlbusarb.sv
// rtlbusarb: round-robin packet arbiter with one-hot owner select and registered output stage
module rtlbusarb #(
  parameter int N = 6,
  parameter int O = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [N*O-1:0] in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   owner,
  output logic           ovld,
  output logic [O-1:0]   odat,
  output logic           olast,
  input  logic           ordy
);
  localparam int W = $clog2(N);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [W-1:0] ptr, own_idx;
  logic [N-1:0] pick;
  logic [O-1:0] sel;
  logic sel_last, take;
  // descending scan so the nearest requester after ptr is assigned last and wins
  always_comb begin
    pick = '0;
    for (int k = N; k >= 1; k--)
      if ((req & (N'(1) << ((int'(ptr) + k) % N))) != '0) pick = N'(1) << ((int'(ptr) + k) % N);
  end
  always_comb begin
    own_idx = '0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (owner[i]) own_idx = W'(i);
      sel = sel | (in[i*O +: O] & {O{owner[i]}});
    end
    sel_last = |(last & owner);
  end
  always_comb begin
    take = !rst && state == BUSY && |(req & owner) && (!ovld || ordy);
    gnt = take ? owner : '0;
    state_n = state;
    if (state == IDLE && |req) state_n = BUSY;
    if (take && sel_last) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= W'(N - 1);
      owner <= '0;
      ovld  <= 1'b0;
      odat  <= '0;
      olast <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) owner <= pick;
      else if (take && sel_last) begin
        owner <= '0;
        ptr   <= own_idx;
      end
      if (take) begin
        ovld  <= 1'b1;
        odat  <= sel;
        olast <= sel_last;
      end else if (ordy) ovld <= 1'b0;
    end
  end
endmodule
